mf_clken_gen: RTL and testbench

//  Multi-channel clock-enable generator with PLL lock supervision.
//  - Runs on the fast PLL output, e.g. 48 MHz.
//  - Replaces extra PLL outputs with NUM_CH phase-aligned enable strobes.

---
 rtl/mf_clken_gen_if.sv | 35 +++
 rtl/mf_clken_gen.sv | 133 +++++++++++++
 tb/tb_mf_clken_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mf_clken_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mf_clken_gen_if : lock/realign inputs and enable/status outputs of          |
// |                   mf_clken_gen                                              |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
interface mf_clken_gen_if #(
  parameter int NUM_CH = 3
);
  logic              pll_locked;
  logic              realign;
  logic [NUM_CH-1:0] ce;
  logic              locked;
  logic              core_rst_n;
  logic              aligned;

  modport master (
    output pll_locked,
    output realign,
    input  ce,
    input  locked,
    input  core_rst_n,
    input  aligned
  );

  modport slave (
    input  pll_locked,
    input  realign,
    output ce,
    output locked,
    output core_rst_n,
    output aligned
  );
endinterface
`default_nettype wire

// File: rtl/mf_clken_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mf_clken_gen : multi-channel phase-aligned clock-enable generator with      |
// |                filtered PLL lock and core reset sequencing                  |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mf_clken_gen #(
  parameter int                      NUM_CH      = 3,
  parameter int                      CNT_W       = 8,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_LIST    = {8'd1, 8'd8, 8'd8},
  parameter logic [NUM_CH*CNT_W-1:0] PHASE_LIST  = {8'd0, 8'd2, 8'd0},
  parameter int                      LOCK_CYCLES = 16
) (
  input  wire logic     refclk,
  input  wire logic     rst_n,
  mf_clken_gen_if.slave bus
);

  localparam int                  c_lock_w   = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [c_lock_w-1:0] c_lock_max = c_lock_w'(LOCK_CYCLES);
  localparam logic [c_lock_w-1:0] c_lock_tgt = c_lock_w'(LOCK_CYCLES - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_align = 2'd1;
  localparam logic [1:0] c_st_run   = 2'd2;

  logic                           r_sync1;
  logic                           r_lk_s;
  logic [c_lock_w-1:0]            r_lock_cnt;
  logic [1:0]                     r_state;
  logic [NUM_CH-1:0][CNT_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]              r_ce;
  logic                           r_locked;
  logic                           r_core_rst_n;
  logic                           r_aligned;

  logic [NUM_CH-1:0][CNT_W-1:0]   w_div_m1;
  logic [NUM_CH-1:0][CNT_W-1:0]   w_load;
  logic [NUM_CH-1:0]              w_at_end;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_err_num_ch
    $error("mf_clken_gen: NUM_CH must be 1..16");
  end
  if (LOCK_CYCLES < 1) begin : g_err_lock
    $error("mf_clken_gen: LOCK_CYCLES must be at least 1");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    if (DIV_LIST[g*CNT_W +: CNT_W] == '0) begin : g_err_div
      $error("mf_clken_gen: divide of channel %0d is zero", g);
    end
    if (PHASE_LIST[g*CNT_W +: CNT_W] >= DIV_LIST[g*CNT_W +: CNT_W]) begin : g_err_phase
      $error("mf_clken_gen: phase of channel %0d is not below its divide", g);
    end
    // Loading DIV-1-PHASE makes the first wrap land PHASE cycles into RUN.
    assign w_div_m1[g] = DIV_LIST[g*CNT_W +: CNT_W] - CNT_W'(1);
    assign w_load[g]   = w_div_m1[g] - PHASE_LIST[g*CNT_W +: CNT_W];
    assign w_at_end[g] = (r_cnt[g] == w_div_m1[g]);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= 1'b0;
      r_lk_s       <= 1'b0;
      r_lock_cnt   <= '0;
      r_state      <= c_st_idle;
      r_cnt        <= '0;
      r_ce         <= '0;
      r_locked     <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_aligned    <= 1'b0;
    end else begin
      r_sync1   <= bus.pll_locked;
      r_lk_s    <= r_sync1;
      r_aligned <= 1'b0;

      if (!r_lk_s) begin
        r_lock_cnt <= '0;
      end else if (r_lock_cnt != c_lock_max) begin
        r_lock_cnt <= r_lock_cnt + c_lock_w'(1);
      end

      // Loss of the synchronised lock overrides everything, including realign.
      if (!r_lk_s) begin
        r_state      <= c_st_idle;
        r_cnt        <= '0;
        r_ce         <= '0;
        r_locked     <= 1'b0;
        r_core_rst_n <= 1'b0;
      end else begin
        case (r_state)
          c_st_idle: begin
            r_ce <= '0;
            if (r_lock_cnt == c_lock_tgt) begin
              r_state  <= c_st_align;
              r_locked <= 1'b1;
            end
          end
          c_st_align: begin
            r_ce      <= '0;
            r_cnt     <= w_load;
            r_aligned <= 1'b1;
            r_state   <= c_st_run;
          end
          c_st_run: begin
            r_core_rst_n <= 1'b1;
            if (bus.realign) begin
              r_state <= c_st_align;
              r_ce    <= '0;
            end else begin
              for (int i = 0; i < NUM_CH; i++) begin
                r_ce[i]  <= w_at_end[i];
                r_cnt[i] <= w_at_end[i] ? '0 : r_cnt[i] + CNT_W'(1);
              end
            end
          end
          default: begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_ce    <= '0;
          end
        endcase
      end
    end
  end

  assign bus.ce         = r_ce;
  assign bus.locked     = r_locked;
  assign bus.core_rst_n = r_core_rst_n;
  assign bus.aligned    = r_aligned;

endmodule
`default_nettype wire

// File: tb/tb_mf_clken_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mf_clken_gen : scoreboard bench for mf_clken_gen (default 3 channels)    |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_mf_clken_gen;

  localparam int NUM_CH = 3;
  localparam int LOCK   = 16;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 refclk = ~refclk;

  mf_clken_gen_if #(.NUM_CH(NUM_CH)) bus ();

  mf_clken_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (8),
    .DIV_LIST    ({8'd1, 8'd8, 8'd8}),
    .PHASE_LIST  ({8'd0, 8'd2, 8'd0}),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // Observed vector: {ce[2:0], locked, core_rst_n, aligned}
  wire [5:0] obs = {bus.ce, bus.locked, bus.core_rst_n, bus.aligned};

  int div_v[NUM_CH] = '{8, 8, 1};
  int ph_v[NUM_CH]  = '{0, 2, 0};

  typedef struct {
    logic [5:0] v;
    string      tag;
    int         t;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected outputs in RUN, t counted from the first RUN cycle.
  function automatic logic [5:0] run_exp(int t, bit core_always);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (t >= ph_v[i] + 1 && ((t - ph_v[i] - 1) % div_v[i]) == 0) c[i] = 1'b1;
    return {c, 1'b1, (core_always || t >= 1), (t == 0)};
  endfunction

  task automatic push(logic [5:0] v, string tag, int t);
    exp_t x;
    x.v = v; x.tag = tag; x.t = t;
    sb.push_back(x);
  endtask

  task automatic push_relock(int zeros, int last_t);
    for (int i = 0; i < zeros; i++) push(6'b000000, "wait_lock", i);
    push(6'b000100, "align", 0);
    for (int t = 0; t <= last_t; t++) push(run_exp(t, 1'b0), "run", t);
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.pll_locked = 1'b1;
    bus.realign    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge refclk);
      n_checks++;
      if (obs !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %b expected %b", i, obs, 6'b000000);
      end
    end
  endtask

  task automatic test_lock_run();
    rst_n       = 1'b1;
    bus.realign = 1'b1;
    push_relock(LOCK + 1, 20);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge refclk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL lock_run %s t=%0d: got %b expected %b", e.tag, e.t, obs, e.v);
      end
      if (i == 3) bus.realign = 1'b0;
    end
  endtask

  task automatic test_realign();
    bus.realign = 1'b1;
    push(6'b000110, "realign_align", 0);
    for (int t = 0; t <= 12; t++) push(run_exp(t, 1'b1), "realign_run", t);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge refclk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL realign %s t=%0d: got %b expected %b", e.tag, e.t, obs, e.v);
      end
      if (i == 1) bus.realign = 1'b0;
    end
  endtask

  task automatic test_lock_loss();
    bus.pll_locked = 1'b0;
    push(run_exp(13, 1'b1), "pre_loss", 13);
    push(run_exp(14, 1'b1), "pre_loss", 14);
    push_relock(LOCK + 2, 12);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge refclk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL lock_loss %s t=%0d: got %b expected %b", e.tag, e.t, obs, e.v);
      end
      if (i == 2) bus.pll_locked = 1'b1;
    end
  endtask

  task automatic test_realign_vs_unlock();
    bus.pll_locked = 1'b0;
    push(run_exp(13, 1'b1), "pre_race", 13);
    push(run_exp(14, 1'b1), "pre_race", 14);
    push_relock(LOCK + 1, 12);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge refclk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL race %s t=%0d: got %b expected %b", e.tag, e.t, obs, e.v);
      end
      if (i == 1) begin
        bus.realign    = 1'b1;
        bus.pll_locked = 1'b1;
      end
      if (i == 2) bus.realign = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 6'b000000) begin
      n_fail++;
      $display("FAIL async_reset_now: got %b expected %b", obs, 6'b000000);
    end
    @(negedge refclk);
    n_checks++;
    if (obs !== 6'b000000) begin
      n_fail++;
      $display("FAIL async_reset_hold: got %b expected %b", obs, 6'b000000);
    end
    rst_n = 1'b1;
    push_relock(LOCK + 1, 12);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge refclk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL post_reset %s t=%0d: got %b expected %b", e.tag, e.t, obs, e.v);
      end
    end
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    bus.realign    = 1'b0;
    test_reset();
    test_lock_run();
    test_realign();
    test_lock_loss();
    test_realign_vs_unlock();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
